hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. Sequences stalls, flushes and forwarding selects for the F/D/E stages.
- Keeps its own M/W shadow of write-back control, so hazard decisions need no extra datapath wiring.
- Schedules a multi-cycle multiplier that occupies E for MUL_LAT cycles.
- Drives ForwardAD/ForwardBD/FlushE of the decode stage and the F/D pipeline-register enables.

Parameters:
- MUL_LAT, 4: cycles a multiply occupies E (legal 1..16). 1 means no stall.
- CNT_W, 4: multiply counter width. Must satisfy 2^CNT_W >= MUL_LAT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- RsD, RtD  in  5 each  source registers in D
- BranchD  in  1  beq/bne in D
- RsE, RtE  in  5 each  source registers in E
- WriteRegE  in  5  destination register in E (after RegDst mux)
- RegWriteE, MemtoRegE  in  1 each  E-stage write-back controls
- MultStartE  in  1  multiply instruction present in E
- StallF, StallD  out  1 each  hold PC / hold D register
- StallE  out  1  hold E register
- FlushE  out  1  insert bubble into E
- ForwardAD, ForwardBD  out  1 each  select ALUOutM for branch compare
- ForwardAE, ForwardBE  out  2 each  00 = regfile, 01 = ResultW, 10 = ALUOutM
- RegWriteM, MemtoRegM, RegWriteW  out  1 each  shadow controls
- WriteRegM, WriteRegW  out  5 each  shadow destinations
- MultBusy  out  1  multiplier stall active

Behaviour:
- Shadow registers update on posedge clk.
  - RegWriteM <= RegWriteE & ~StallE; MemtoRegM <= MemtoRegE & ~StallE. A held E stage sends a bubble to M.
  - WriteRegM <= WriteRegE; RegWriteW <= RegWriteM; WriteRegW <= WriteRegM.
  - Reset clears every shadow to 0, FSM to IDLE, counter to 0.
- Forwarding is combinational, zero latency. Register $0 is never forwarded.
  - ForwardAE = 10 if RegWriteM & WriteRegM!=0 & WriteRegM==RsE.
  - Otherwise ForwardAE = 01 if RegWriteW & WriteRegW!=0 & WriteRegW==RsE.
  - Otherwise ForwardAE = 00. ForwardBE uses the same rules with RtE. M priority beats W.
  - ForwardAD = RsD!=0 & RegWriteM & WriteRegM==RsD. ForwardBD is the same with RtD.
- lwstall = MemtoRegE & RtE!=0 & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & ( (RegWriteE & WriteRegE!=0 & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & WriteRegM!=0 & (WriteRegM==RsD | WriteRegM==RtD)) ).
- Multiplier FSM, states IDLE/BUSY/DONE. mstall is the FSM's combinational output.
  - IDLE: if MultStartE & MUL_LAT>1: mstall=1, cnt <= MUL_LAT-2, next = DONE if MUL_LAT==2, else BUSY. Otherwise mstall=0 and stay.
  - BUSY: mstall=1, cnt <= cnt-1, next = DONE if cnt==1, else BUSY.
  - DONE: mstall=0, MultStartE ignored (the same multiply is leaving E), next = IDLE.
  - Net effect: the multiply occupies E exactly MUL_LAT cycles, with mstall high for the first MUL_LAT-1. Back-to-back multiplies each pay the full latency.
- Output combination:
  - MultBusy = mstall; StallE = mstall.
  - StallF = StallD = mstall | lwstall | branchstall.
  - FlushE = (lwstall | branchstall) & ~mstall. A held E is never flushed; the multiplier has priority.
- While reset is high, StallF/StallD/StallE/FlushE/MultBusy are forced to 0. Forwards are 0 because the shadows are cleared.
- Reset mid-multiply: FSM returns to IDLE on that edge. mstall is low from the first cycle reset is low, unless MultStartE is still high.

Test Plan:
- Reset, then RegWriteE=1, WriteRegE=8, one cycle later RsE=8 → RegWriteM=1, WriteRegM=8, ForwardAE=10. Next cycle, RsE=8 and E idle → ForwardAE=01. WriteRegE=0 case → ForwardAE stays 00.
- MemtoRegE=1, RtE=9, RsD=9 → StallF=StallD=FlushE=1 for exactly 1 cycle. Next cycle MemtoRegM=1, no stall, ForwardAE=10 only if RegWriteM.
- BranchD=1, RsD=16, RegWriteE=1, WriteRegE=16 → 1-cycle stall + FlushE. Following cycle ForwardAD=1, no stall.
- MUL_LAT=4, MultStartE held high → MultBusy=StallE=StallF=1 for cycles t..t+2, 0 at t+3 (DONE). RegWriteM=0 for bubbles at t+1..t+3. Repeat with MUL_LAT=1 → no stall ever.
- Multiply busy while BranchD hazard is present → FlushE=0, StallE=1. FlushE=1 appears only in the DONE cycle if the hazard persists.
- Reset asserted at t+1 of a MUL_LAT=4 multiply → all stalls 0 during reset. Shadows 0 afterwards. FSM IDLE, restarts a full 4-cycle count if MultStartE is still high.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard controller for the 5-stage MIPS pipeline. It produces the stall,
//   flush and forwarding selects for the F/D/E stages. It keeps a private
//   M/W shadow of the write-back controls, so the decisions need no extra
//   datapath taps. It also sequences a multi-cycle multiplier that holds E
//   for MUL_LAT cycles.
//
// Parameters
//   MUL_LAT : cycles a multiply occupies E (1..16). 1 means no stall.
//   CNT_W   : multiply counter width, 2**CNT_W >= MUL_LAT.
//
// Ports
//   clk, reset                    : rising-edge clock, synchronous active-high reset
//   RsD, RtD, BranchD             : decode-stage sources and branch flag
//   RsE, RtE, WriteRegE           : execute-stage sources and destination
//   RegWriteE, MemtoRegE          : execute-stage write-back controls
//   MultStartE                    : multiply instruction present in E
//   StallF, StallD, StallE        : hold PC / D register / E register
//   FlushE                        : insert a bubble into E
//   ForwardAD, ForwardBD          : branch comparator takes ALUOutM
//   ForwardAE, ForwardBE          : 00 regfile, 01 ResultW, 10 ALUOutM
//   RegWriteM, MemtoRegM, RegWriteW, WriteRegM, WriteRegW : shadow controls
//   MultBusy                      : multiplier stall active
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       BranchD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       MultStartE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       RegWriteM,
  output logic       MemtoRegM,
  output logic       RegWriteW,
  output logic [4:0] WriteRegM,
  output logic [4:0] WriteRegW,
  output logic       MultBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // A one-cycle multiply never needs to hold E, so the FSM stays in IDLE.
  localparam bit MUL_MULTI = (MUL_LAT > 1);
  localparam bit LAT_TWO   = (MUL_LAT == 2);
  // The first cycle is spent in IDLE and the last in DONE, so BUSY counts
  // the remaining MUL_LAT-2 cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = MUL_MULTI ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Non-zero destination that matches either decode source.
  function automatic logic reg_hit(input logic [4:0] dst,
                                   input logic [4:0] src_a,
                                   input logic [4:0] src_b);
    return (dst != 5'd0) && ((dst == src_a) || (dst == src_b));
  endfunction

  // Execute-stage forward select. M wins over W, and $0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       rw_m,
                                         input logic [4:0] wr_m,
                                         input logic       rw_w,
                                         input logic [4:0] wr_w);
    logic [1:0] sel;
    if (rw_m && (wr_m != 5'd0) && (wr_m == src)) begin
      sel = 2'b10;
    end else if (rw_w && (wr_w != 5'd0) && (wr_w == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  mul_state_t       state_r;
  mul_state_t       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             mstall_s;
  logic             lwstall_s;
  logic             branchstall_s;
  logic             hazard_s;
  logic             stall_e_s;

  logic             regwrite_m_r;
  logic             memtoreg_m_r;
  logic [4:0]       writereg_m_r;
  logic             regwrite_w_r;
  logic [4:0]       writereg_w_r;

  // Multiplier next-state, counter and stall decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mstall_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (MultStartE && MUL_MULTI) begin
          mstall_s    = 1'b1;
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = LAT_TWO ? DONE : BUSY;
        end else begin
          mstall_s    = 1'b0;
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        mstall_s  = 1'b1;
        cnt_nxt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        // The finishing multiply leaves E this cycle; a start request seen
        // now belongs to it and is ignored.
        mstall_s    = 1'b0;
        state_nxt_s = IDLE;
      end
      default: begin
        mstall_s    = 1'b0;
        cnt_nxt_s   = '0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Multiplier state and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Load-use and branch-compare hazard detection.
  assign lwstall_s     = MemtoRegE && reg_hit(RtE, RsD, RtD);
  assign branchstall_s = BranchD &&
                         ((RegWriteE && reg_hit(WriteRegE, RsD, RtD)) ||
                          (memtoreg_m_r && reg_hit(writereg_m_r, RsD, RtD)));
  assign hazard_s      = lwstall_s || branchstall_s;

  // All stall/flush outputs are quiet while reset is asserted.
  assign stall_e_s = mstall_s && !reset;
  assign StallE    = stall_e_s;
  assign MultBusy  = stall_e_s;
  assign StallF    = !reset && (mstall_s || hazard_s);
  assign StallD    = !reset && (mstall_s || hazard_s);
  // A held E stage must keep its instruction, so the multiplier wins.
  assign FlushE    = !reset && hazard_s && !mstall_s;

  // M/W shadow of the write-back controls; a held E sends a bubble to M.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_m_r <= 1'b0;
      memtoreg_m_r <= 1'b0;
      writereg_m_r <= 5'd0;
      regwrite_w_r <= 1'b0;
      writereg_w_r <= 5'd0;
    end else begin
      regwrite_m_r <= RegWriteE && !stall_e_s;
      memtoreg_m_r <= MemtoRegE && !stall_e_s;
      writereg_m_r <= WriteRegE;
      regwrite_w_r <= regwrite_m_r;
      writereg_w_r <= writereg_m_r;
    end
  end

  assign RegWriteM = regwrite_m_r;
  assign MemtoRegM = memtoreg_m_r;
  assign WriteRegM = writereg_m_r;
  assign RegWriteW = regwrite_w_r;
  assign WriteRegW = writereg_w_r;

  // Forwarding selects, zero latency.
  assign ForwardAE = fwd_sel(RsE, regwrite_m_r, writereg_m_r, regwrite_w_r, writereg_w_r);
  assign ForwardBE = fwd_sel(RtE, regwrite_m_r, writereg_m_r, regwrite_w_r, writereg_w_r);
  assign ForwardAD = (RsD != 5'd0) && regwrite_m_r && (writereg_m_r == RsD);
  assign ForwardBD = (RtD != 5'd0) && regwrite_m_r && (writereg_m_r == RtD);

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. Two instances share the stimulus:
//   index 0 has MUL_LAT=4 and index 1 has MUL_LAT=1. A behavioural model
//   tracks the pipeline contents and how many cycles the current multiply
//   still owns E. Outputs are compared every cycle. Directed literal checks
//   pin the main scenarios before a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE;
  logic       BranchD, RegWriteE, MemtoRegE, MultStartE;

  logic       stallf[2], stalld[2], stalle[2], flushe[2], fad[2], fbd[2];
  logic [1:0] fae[2], fbe[2];
  logic       rwm[2], mtrm[2], rww[2], busy[2];
  logic [4:0] wrm[2], wrw[2];

  hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MultStartE(MultStartE),
    .StallF(stallf[0]), .StallD(stalld[0]), .StallE(stalle[0]), .FlushE(flushe[0]),
    .ForwardAD(fad[0]), .ForwardBD(fbd[0]), .ForwardAE(fae[0]), .ForwardBE(fbe[0]),
    .RegWriteM(rwm[0]), .MemtoRegM(mtrm[0]), .RegWriteW(rww[0]),
    .WriteRegM(wrm[0]), .WriteRegW(wrw[0]), .MultBusy(busy[0])
  );

  hazard_ctrl #(.MUL_LAT(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MultStartE(MultStartE),
    .StallF(stallf[1]), .StallD(stalld[1]), .StallE(stalle[1]), .FlushE(flushe[1]),
    .ForwardAD(fad[1]), .ForwardBD(fbd[1]), .ForwardAE(fae[1]), .ForwardBE(fbe[1]),
    .RegWriteM(rwm[1]), .MemtoRegM(mtrm[1]), .RegWriteW(rww[1]),
    .WriteRegM(wrm[1]), .WriteRegW(wrw[1]), .MultBusy(busy[1])
  );

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0] occ;    // cycles the multiply in E still owns E (0 = none)
    logic       m_rw;
    logic       m_mtr;
    logic [4:0] m_wr;
    logic       w_rw;
    logic [4:0] w_wr;
  } mst_t;

  mst_t ms[2] = '{default: '0};
  bit   valid = 1'b0;

  function automatic int lat(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Does a non-zero register feed either decode source?
  function automatic bit reads_d(input logic [4:0] r);
    return (r != 5'd0) && ((r == RsD) || (r == RtD));
  endfunction

  // Walk the producers from the nearest stage outward; first writer wins.
  function automatic logic [1:0] exp_fwd(input mst_t s, input logic [4:0] src);
    logic [4:0] dst[2];
    logic       wr[2];
    logic [1:0] code[2];
    dst  = '{s.m_wr, s.w_wr};
    wr   = '{s.m_rw, s.w_rw};
    code = '{2'b10, 2'b01};
    for (int k = 0; k < 2; k++) begin
      if (wr[k] && (dst[k] != 5'd0) && (dst[k] == src)) return code[k];
    end
    return 2'b00;
  endfunction

  // Cycles owned by the multiply in E this cycle, including a new start.
  function automatic int occ_now(input mst_t s, input int l);
    return ((s.occ == 5'd0) && MultStartE) ? l : int'(s.occ);
  endfunction

  function automatic logic [23:0] exp_vec(input mst_t s, input int l);
    bit m, lw, br, hz, st;
    m  = !reset && (occ_now(s, l) > 1);
    lw = MemtoRegE && reads_d(RtE);
    br = BranchD && ((RegWriteE && reads_d(WriteRegE)) || (s.m_mtr && reads_d(s.m_wr)));
    hz = !reset && (lw || br);
    st = m || hz;
    return {st, st, m, hz && !m,
            s.m_rw && (RsD != 5'd0) && (s.m_wr == RsD),
            s.m_rw && (RtD != 5'd0) && (s.m_wr == RtD),
            exp_fwd(s, RsE), exp_fwd(s, RtE),
            s.m_rw, s.m_mtr, s.w_rw, s.m_wr, s.w_wr, m};
  endfunction

  function automatic mst_t nxt(input mst_t s, input int l);
    mst_t n;
    int   o;
    bit   m;
    n = '0;
    if (!reset) begin
      o = occ_now(s, l);
      m = (o > 1);
      n.occ   = (o > 0) ? 5'(o - 1) : 5'd0;
      n.m_rw  = RegWriteE && !m;
      n.m_mtr = MemtoRegE && !m;
      n.m_wr  = WriteRegE;
      n.w_rw  = s.m_rw;
      n.w_wr  = s.m_wr;
    end
    return n;
  endfunction

  function automatic logic [23:0] dut_vec(input int i);
    return {stallf[i], stalld[i], stalle[i], flushe[i], fad[i], fbd[i], fae[i], fbe[i],
            rwm[i], mtrm[i], rww[i], wrm[i], wrw[i], busy[i]};
  endfunction

  // Advance the model on the same edge as the DUT.
  always @(posedge clk) begin
    if (reset) valid <= 1'b1;
    ms[0] <= nxt(ms[0], 4);
    ms[1] <= nxt(ms[1], 1);
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (valid) begin
      for (int i = 0; i < 2; i++) begin
        logic [23:0] e, g;
        e = exp_vec(ms[i], lat(i));
        g = dut_vec(i);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL model_cmp lat=%0d t=%0t got=%h exp=%h", lat(i), $time, g, e);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0; WriteRegE = 5'd0;
    BranchD = 1'b0; RegWriteE = 1'b0; MemtoRegE = 1'b0; MultStartE = 1'b0;
  endtask

  initial begin
    // Reset with every hazard source active: stalls must stay quiet.
    idle();
    reset = 1'b1;
    MultStartE = 1'b1; MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd9;
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9;
    look();
    chk("reset_stalls", {stallf[0], stalld[0], stalle[0], flushe[0], busy[0]}, 32'h0);
    chk("reset_shadow", {rwm[0], mtrm[0], rww[0], wrm[0], wrw[0]}, 32'h0);
    cyc(); reset = 1'b0; idle();

    // Forwarding from M, then from W, and never for $0.
    cyc(); RegWriteE = 1'b1; WriteRegE = 5'd8;
    cyc(); idle(); RsE = 5'd8;
    look();
    chk("fwd_m_rw", rwm[0], 32'h1);
    chk("fwd_m_wr", wrm[0], 32'h8);
    chk("fwd_ae_m", fae[0], 32'h2);
    cyc(); idle(); RsE = 5'd8;
    look();
    chk("fwd_ae_w", fae[0], 32'h1);
    cyc(); idle(); RegWriteE = 1'b1;
    cyc(); idle();
    look();
    chk("fwd_zero_m", fae[0], 32'h0);
    cyc(); idle();
    look();
    chk("fwd_zero_w", fae[0], 32'h0);

    // Load-use stall for exactly one cycle.
    cyc(); idle(); MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; RtE = 5'd9; RsD = 5'd9;
    look();
    chk("lw_stall", {stallf[0], stalld[0], stalle[0], flushe[0]}, 32'hD);
    cyc(); idle(); RsE = 5'd9;
    look();
    chk("lw_after_stall", {stallf[0], flushe[0]}, 32'h0);
    chk("lw_after_mtrm", mtrm[0], 32'h1);
    chk("lw_after_fwd", fae[0], 32'h2);

    // Branch compare hazard on an E-stage producer, then forward from M.
    cyc(); idle(); BranchD = 1'b1; RsD = 5'd16; RegWriteE = 1'b1; WriteRegE = 5'd16;
    look();
    chk("br_stall", {stallf[0], stalld[0], flushe[0]}, 32'h7);
    cyc(); idle(); BranchD = 1'b1; RsD = 5'd16;
    look();
    chk("br_fwd_ad", fad[0], 32'h1);
    chk("br_no_stall", stallf[0], 32'h0);
    cyc(); idle();

    // Multiply held high: three stall cycles then DONE; lat 1 never stalls.
    cyc(); idle(); MultStartE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5;
    look();
    chk("mul_t0_busy", {busy[0], stalle[0], stallf[0]}, 32'h7);
    chk("mul1_t0", {busy[1], stallf[1]}, 32'h0);
    for (int k = 1; k <= 2; k++) begin
      cyc();
      look();
      chk("mul_tk_busy", {busy[0], stalle[0], stallf[0]}, 32'h7);
      chk("mul_tk_bubble", rwm[0], 32'h0);
    end
    cyc();
    look();
    chk("mul_t3_done", {busy[0], stalle[0], stallf[0]}, 32'h0);
    chk("mul_t3_bubble", rwm[0], 32'h0);
    chk("mul1_t3_rw", rwm[1], 32'h1);

    // Back-to-back multiply with a branch hazard: flush only in DONE.
    cyc(); BranchD = 1'b1; RsD = 5'd16; WriteRegE = 5'd16;
    look();
    chk("mulbr_t4", {stalle[0], flushe[0]}, 32'h2);
    chk("mul1br_t4", flushe[1], 32'h1);
    for (int k = 5; k <= 6; k++) begin
      cyc();
      look();
      chk("mulbr_tk", {stalle[0], flushe[0]}, 32'h2);
    end
    cyc();
    look();
    chk("mulbr_done", {stalle[0], flushe[0], stallf[0]}, 32'h3);
    cyc(); idle();

    // Reset in the middle of a multiply; a held start restarts the count.
    cyc(); idle(); MultStartE = 1'b1; WriteRegE = 5'd7;
    look();
    chk("mrst_s0", busy[0], 32'h1);
    cyc(); reset = 1'b1;
    look();
    chk("mrst_in_reset", {stallf[0], stalld[0], stalle[0], flushe[0], busy[0]}, 32'h0);
    cyc();
    look();
    chk("mrst_in_reset2", {stallf[0], stalle[0], busy[0]}, 32'h0);
    cyc(); reset = 1'b0;
    look();
    chk("mrst_restart", busy[0], 32'h1);
    chk("mrst_shadow", {rwm[0], wrm[0], rww[0], wrw[0]}, 32'h0);
    for (int k = 4; k <= 5; k++) begin
      cyc();
      look();
      chk("mrst_busy", busy[0], 32'h1);
    end
    cyc();
    look();
    chk("mrst_done", busy[0], 32'h0);
    cyc(); idle();

    // Randomized phase against the model; small register range forces hits.
    repeat (3000) begin
      cyc();
      reset      = ($urandom_range(0, 63) == 0);
      RsD        = 5'($urandom_range(0, 3));
      RtD        = 5'($urandom_range(0, 3));
      RsE        = 5'($urandom_range(0, 3));
      RtE        = 5'($urandom_range(0, 3));
      WriteRegE  = 5'($urandom_range(0, 3));
      BranchD    = ($urandom_range(0, 3) == 0);
      RegWriteE  = ($urandom_range(0, 1) == 0);
      MemtoRegE  = ($urandom_range(0, 3) == 0);
      MultStartE = ($urandom_range(0, 3) == 0);
    end
    cyc(); idle(); reset = 1'b0;
    look();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
